// File: rtl/pin_control_dt_pkg.sv
// Shared types and constants for the multi-channel dead-time pin controller.
// Imported by the per-channel FSM and the top level.
package pin_control_pkg;

    typedef enum logic [2:0] {
        SAFE  = 3'd0,
        A_ON  = 3'd1,
        DT_AB = 3'd2,
        B_ON  = 3'd3,
        DT_BA = 3'd4
    } pin_state_t;

    localparam int POL_A_BIT = 0;
    localparam int POL_B_BIT = 1;

    // Demand is A only when neither compare match is active.
    function automatic logic demandIsA(input logic matchHigh, input logic matchLow);
        return ~matchHigh & ~matchLow;
    endfunction

endpackage

// File: rtl/pin_control_dt_if.sv
// Bus between the PWM counter/comparator bank (master) and the pin controller (slave).
// Carries configuration, compare matches and the gate pin outputs.
interface pin_control_dt_if #(
    parameter int N_CHANNELS = 3,
    parameter int DT_WIDTH   = 8
);
    logic [2*N_CHANNELS-1:0] enable_outputs;
    logic                    counter_stopped;
    logic [N_CHANNELS-1:0]   match_high;
    logic [N_CHANNELS-1:0]   match_low;
    logic [DT_WIDTH-1:0]     dead_time;
    logic [1:0]              polarity;
    logic [N_CHANNELS-1:0]   out_a;
    logic [N_CHANNELS-1:0]   out_b;

    modport master (
        output enable_outputs,
        output counter_stopped,
        output match_high,
        output match_low,
        output dead_time,
        output polarity,
        input  out_a,
        input  out_b
    );

    modport slave (
        input  enable_outputs,
        input  counter_stopped,
        input  match_high,
        input  match_low,
        input  dead_time,
        input  polarity,
        output out_a,
        output out_b
    );
endinterface

// File: rtl/pin_control_dt_dt_channel.sv
// Single complementary channel: demand-following FSM with a dead-time down-counter.
//
//   state | meaning
//   SAFE  | counter stopped, both gates off
//   A_ON  | high-side gate on
//   DT_AB | gap before handing over to B
//   B_ON  | low-side gate on
//   DT_BA | gap before handing over to A
module dt_channel
    import pin_control_pkg::*;
#(
    parameter int DT_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                counterStopped,
    input  logic                demandA,
    input  logic [DT_WIDTH-1:0] deadTime,
    output logic                aLog,
    output logic                bLog
);

    pin_state_t          state;
    pin_state_t          stateNext;
    logic [DT_WIDTH-1:0] count;
    logic [DT_WIDTH-1:0] countNext;
    logic                gapDone;

    // Terminal compare at 1 so the gap is dead_time cycles, and a zero load still costs one cycle.
    assign gapDone = (count <= DT_WIDTH'(1));

    always_comb begin
        stateNext = state;
        countNext = count;
        if (counterStopped) begin
            stateNext = SAFE;
            countNext = '0;
        end else begin
            case (state)
                SAFE: begin
                    stateNext = demandA ? DT_BA : DT_AB;
                    countNext = deadTime;
                end
                A_ON: begin
                    if (!demandA) begin
                        stateNext = DT_AB;
                        countNext = deadTime;
                    end
                end
                B_ON: begin
                    if (demandA) begin
                        stateNext = DT_BA;
                        countNext = deadTime;
                    end
                end
                DT_AB: begin
                    if (demandA) begin
                        stateNext = A_ON;
                        countNext = '0;
                    end else if (gapDone) begin
                        stateNext = B_ON;
                        countNext = '0;
                    end else begin
                        countNext = count - DT_WIDTH'(1);
                    end
                end
                DT_BA: begin
                    if (!demandA) begin
                        stateNext = B_ON;
                        countNext = '0;
                    end else if (gapDone) begin
                        stateNext = A_ON;
                        countNext = '0;
                    end else begin
                        countNext = count - DT_WIDTH'(1);
                    end
                end
                default: begin
                    stateNext = SAFE;
                    countNext = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SAFE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    assign aLog = (state == A_ON);
    assign bLog = (state == B_ON);

endmodule

// File: rtl/pin_control_dt.sv
// Multi-channel complementary gate driver with dead-time, enable masking and polarity.
// One dt_channel per output pair; gate drive is registered one cycle after the FSM.
module pin_control_dt
    import pin_control_pkg::*;
#(
    parameter int N_CHANNELS = 3,
    parameter int DT_WIDTH   = 8
) (
    input logic             clock,
    input logic             reset,
    pin_control_dt_if.slave pins
);

    logic [N_CHANNELS-1:0] demandA;
    logic [N_CHANNELS-1:0] aLogVec;
    logic [N_CHANNELS-1:0] bLogVec;
    logic [N_CHANNELS-1:0] enableA;
    logic [N_CHANNELS-1:0] enableB;
    logic [N_CHANNELS-1:0] gateA;
    logic [N_CHANNELS-1:0] gateB;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : gChannel
        assign demandA[i] = demandIsA(pins.match_high[i], pins.match_low[i]);
        assign enableA[i] = pins.enable_outputs[2*i];
        assign enableB[i] = pins.enable_outputs[2*i+1];

        dt_channel #(
            .DT_WIDTH(DT_WIDTH)
        ) uChannel (
            .clock          (clock),
            .reset          (reset),
            .counterStopped (pins.counter_stopped),
            .demandA        (demandA[i]),
            .deadTime       (pins.dead_time),
            .aLog           (aLogVec[i]),
            .bLog           (bLogVec[i])
        );
    end

    // Masking does not touch the FSMs; a disabled side simply never drives its gate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gateA <= '0;
            gateB <= '0;
        end else begin
            gateA <= aLogVec & enableA;
            gateB <= bLogVec & enableB;
        end
    end

    // Polarity is static configuration applied after the register, so the pins sit at
    // their inactive level throughout reset without an async load of a data input.
    assign pins.out_a = gateA ^ {N_CHANNELS{pins.polarity[POL_A_BIT]}};
    assign pins.out_b = gateB ^ {N_CHANNELS{pins.polarity[POL_B_BIT]}};

endmodule

// File: tb/tb_pin_control_dt.sv
// Self-checking bench for pin_control_dt: vector table, timing sequences and
// randomized traffic against a side/gap reference model.
module tb_pin_control_dt;

    localparam int NCH = 3;
    localparam int DTW = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   modelArmed = 1'b0;

    pin_control_dt_if #(.N_CHANNELS(NCH), .DT_WIDTH(DTW)) bus ();

    pin_control_dt #(.N_CHANNELS(NCH), .DT_WIDTH(DTW)) dut (
        .clock (clock),
        .reset (reset),
        .pins  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: which side is conducting (0 none, 1 A, 2 B), which side a gap
    // is heading to, and how many gap cycles remain.
    int onSide [NCH] = '{default: 0};
    int pendSide [NCH] = '{default: 0};
    int gapLeft [NCH] = '{default: 0};
    logic [NCH-1:0] expGateA = '0;
    logic [NCH-1:0] expGateB = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                onSide[c] = 0;
                pendSide[c] = 0;
                gapLeft[c] = 0;
            end
            expGateA = '0;
            expGateB = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                expGateA[c] = (onSide[c] == 1) && bus.enable_outputs[2*c];
                expGateB[c] = (onSide[c] == 2) && bus.enable_outputs[2*c+1];
            end
            for (int c = 0; c < NCH; c++) begin
                int want;
                want = (!bus.match_high[c] && !bus.match_low[c]) ? 1 : 2;
                if (bus.counter_stopped) begin
                    onSide[c] = 0;
                    pendSide[c] = 0;
                end else if (onSide[c] == 0 && pendSide[c] == 0) begin
                    pendSide[c] = want;
                    gapLeft[c] = int'(bus.dead_time);
                end else if (onSide[c] != 0) begin
                    if (want != onSide[c]) begin
                        onSide[c] = 0;
                        pendSide[c] = want;
                        gapLeft[c] = int'(bus.dead_time);
                    end
                end else if (want != pendSide[c]) begin
                    onSide[c] = want;
                    pendSide[c] = 0;
                end else if (gapLeft[c] <= 1) begin
                    onSide[c] = pendSide[c];
                    pendSide[c] = 0;
                end else begin
                    gapLeft[c] = gapLeft[c] - 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        #1;
        if (modelArmed) begin
            logic [NCH-1:0] actA;
            logic [NCH-1:0] actB;
            check("model_out_a", 32'(bus.out_a), 32'(expGateA ^ {NCH{bus.polarity[0]}}));
            check("model_out_b", 32'(bus.out_b), 32'(expGateB ^ {NCH{bus.polarity[1]}}));
            actA = bus.out_a ^ {NCH{bus.polarity[0]}};
            actB = bus.out_b ^ {NCH{bus.polarity[1]}};
            check("never_both_active", 32'(actA & actB), 32'd0);
        end
    end

    typedef struct {
        logic [1:0]     pol;
        logic [5:0]     en;
        logic           stop;
        logic [NCH-1:0] mh;
        logic [NCH-1:0] ml;
        logic [DTW-1:0] dt;
        int             cyc;
        logic [NCH-1:0] expA;
        logic [NCH-1:0] expB;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n;
        int viol;
        int bothOff;
        logic [19:0] seqA;
        logic [19:0] seqB;

        vecs[0] = '{2'b00, 6'h3F, 1'b1, 3'b000, 3'b000, 8'd5, 4,  3'b000, 3'b000};
        vecs[1] = '{2'b11, 6'h3F, 1'b1, 3'b000, 3'b000, 8'd5, 4,  3'b111, 3'b111};
        vecs[2] = '{2'b00, 6'h3F, 1'b0, 3'b000, 3'b000, 8'd2, 10, 3'b111, 3'b000};
        vecs[3] = '{2'b00, 6'h3F, 1'b0, 3'b111, 3'b000, 8'd2, 10, 3'b000, 3'b111};
        vecs[4] = '{2'b00, 6'h3F, 1'b0, 3'b001, 3'b010, 8'd2, 10, 3'b100, 3'b011};
        vecs[5] = '{2'b00, 6'h15, 1'b0, 3'b001, 3'b010, 8'd2, 4,  3'b100, 3'b000};
        vecs[6] = '{2'b01, 6'h3F, 1'b0, 3'b001, 3'b010, 8'd2, 4,  3'b011, 3'b011};
        vecs[7] = '{2'b10, 6'h3F, 1'b0, 3'b000, 3'b000, 8'd2, 10, 3'b111, 3'b111};
        vecs[8] = '{2'b00, 6'h3F, 1'b0, 3'b101, 3'b000, 8'd0, 6,  3'b010, 3'b101};
        vecs[9] = '{2'b10, 6'h3F, 1'b1, 3'b101, 3'b000, 8'd0, 3,  3'b000, 3'b111};

        bus.polarity = 2'b10;
        bus.enable_outputs = 6'h3F;
        bus.counter_stopped = 1'b1;
        bus.match_high = '0;
        bus.match_low = '0;
        bus.dead_time = 8'd5;
        #12;
        check("reset_out_a", 32'(bus.out_a), 32'h0);
        check("reset_out_b", 32'(bus.out_b), 32'h7);
        repeat (2) @(negedge clock);
        check("reset_clocked_out_b", 32'(bus.out_b), 32'h7);
        reset = 1'b1;
        modelArmed = 1'b1;
        repeat (4) @(negedge clock);
        check("stopped_hold_a", 32'(bus.out_a), 32'h0);
        check("stopped_hold_b", 32'(bus.out_b), 32'h7);

        for (int v = 0; v < 10; v++) begin
            bus.polarity = vecs[v].pol;
            bus.enable_outputs = vecs[v].en;
            bus.counter_stopped = vecs[v].stop;
            bus.match_high = vecs[v].mh;
            bus.match_low = vecs[v].ml;
            bus.dead_time = vecs[v].dt;
            repeat (vecs[v].cyc) @(negedge clock);
            check($sformatf("vec%0d_out_a", v), 32'(bus.out_a), 32'(vecs[v].expA));
            check($sformatf("vec%0d_out_b", v), 32'(bus.out_b), 32'(vecs[v].expB));
        end

        // First pulse after leaving SAFE: a full dead_time gap, then one register stage.
        bus.polarity = 2'b00;
        bus.match_high = '0;
        bus.match_low = '0;
        bus.dead_time = 8'd5;
        repeat (3) @(negedge clock);
        bus.counter_stopped = 1'b0;
        n = 0;
        viol = 0;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (bus.out_b != 0) viol++;
            if (bus.out_a[0]) break;
        end
        check("start_gap_a_delay", 32'(n), 32'd7);
        check("start_b_quiet", 32'(viol), 32'd0);

        // A to B hand-over with dead_time=3.
        bus.dead_time = 8'd3;
        repeat (2) @(negedge clock);
        bus.match_high = 3'b001;
        bothOff = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            seqA[j] = bus.out_a[0];
            seqB[j] = bus.out_b[0];
            if (!bus.out_a[0] && !bus.out_b[0]) bothOff++;
        end
        check("ab_out_a_trace", 32'(seqA), 32'h00001);
        check("ab_out_b_trace", 32'(seqB), 32'hFFFF0);
        check("ab_gap_cycles", 32'(bothOff), 32'd3);

        bus.match_high = 3'b000;
        repeat (10) @(negedge clock);
        check("back_to_a", 32'(bus.out_a), 32'h7);

        // Demand reversal inside DT_AB: B must never assert.
        bus.dead_time = 8'd4;
        seqA = '0;
        seqB = '0;
        bus.match_high = 3'b001;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            seqA[j] = bus.out_a[0];
            seqB[j] = bus.out_b[0];
            if (j == 1) bus.match_high = 3'b000;
        end
        check("reversal_out_a_trace", 32'(seqA[9:0]), 32'h3F9);
        check("reversal_out_b_trace", 32'(seqB[9:0]), 32'h000);

        // Stop during DT_BA, then restart.
        bus.dead_time = 8'd2;
        bus.match_high = 3'b111;
        repeat (8) @(negedge clock);
        bus.dead_time = 8'd6;
        bus.match_high = 3'b000;
        repeat (3) @(negedge clock);
        bus.counter_stopped = 1'b1;
        repeat (2) @(negedge clock);
        check("stop_mid_dtba_a", 32'(bus.out_a), 32'h0);
        check("stop_mid_dtba_b", 32'(bus.out_b), 32'h0);
        bus.match_high = 3'b111;
        bus.counter_stopped = 1'b0;
        n = 0;
        viol = 0;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (bus.out_a != 0) viol++;
            if (bus.out_b[0]) break;
        end
        check("restart_b_delay", 32'(n), 32'd8);
        check("restart_a_quiet", 32'(viol), 32'd0);

        // Stop during B_ON with both outputs active-low, then restart towards A.
        repeat (2) @(negedge clock);
        bus.polarity = 2'b11;
        @(negedge clock);
        bus.counter_stopped = 1'b1;
        repeat (2) @(negedge clock);
        check("stop_mid_bon_a", 32'(bus.out_a), 32'h7);
        check("stop_mid_bon_b", 32'(bus.out_b), 32'h7);
        bus.match_high = 3'b000;
        bus.counter_stopped = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (!bus.out_a[0]) break;
        end
        check("restart_a_delay", 32'(n), 32'd8);

        // Random traffic, all outputs enabled, polarity wandering.
        bus.enable_outputs = 6'h3F;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if ($urandom_range(7) == 0) bus.match_high = 3'($urandom);
            if ($urandom_range(7) == 0) bus.match_low = 3'($urandom);
            if ($urandom_range(15) == 0) bus.dead_time = 8'($urandom_range(7));
            bus.counter_stopped = ($urandom_range(63) == 0);
            if ($urandom_range(199) == 0) bus.polarity = 2'($urandom);
        end

        // Masked configuration: out_a[0] and out_b[1] disabled, both sides active-low.
        bus.enable_outputs = 6'b000110;
        bus.polarity = 2'b11;
        bus.counter_stopped = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clock);
            #2;
            check("masked_out_a0", 32'(bus.out_a[0]), 32'd1);
            check("masked_out_b1", 32'(bus.out_b[1]), 32'd1);
            bus.match_high = 3'($urandom);
            bus.match_low = 3'($urandom);
            if ($urandom_range(31) == 0) bus.dead_time = 8'($urandom_range(5));
            bus.counter_stopped = ($urandom_range(127) == 0);
        end

        modelArmed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
